// File: rtl/csr_trap_sequencer_pkg.sv
// Shared CSR addresses, cause codes, mstatus bit positions and instruction encodings
package csr_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_ECALL_M      = 11;
  localparam int CAUSE_ILLEGAL_INST = 2;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_UNIMP = 32'hc000_1073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  // Classification of the instruction sitting in MEM
  typedef struct packed {
    logic trap_ecall;
    logic trap_unimp;
    logic is_mret;
    logic plain_wr;
  } mem_class_t;

endpackage

// File: rtl/csr_trap_decode.sv
// Combinational MEM-stage classifier: ecall / unimp / mret / ordinary CSR write
module csr_trap_decode
  import csr_trap_sequencer_pkg::*;
(
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_csr_write_i,
  input  logic        mem_is_mret_i,
  output mem_class_t  cls_o
);

  logic ecall_raw, unimp_raw;

  assign ecall_raw = (mem_inst_i == INST_ECALL);
  assign unimp_raw = (mem_inst_i == INST_UNIMP);

  // A plain write never coexists with a trap or mret, so traps always win
  assign cls_o.trap_ecall = mem_valid_i && ecall_raw;
  assign cls_o.trap_unimp = mem_valid_i && unimp_raw;
  assign cls_o.is_mret    = mem_valid_i && mem_is_mret_i;
  assign cls_o.plain_wr   = mem_valid_i && mem_csr_write_i &&
                            !(ecall_raw || unimp_raw || mem_is_mret_i);

endmodule

// File: rtl/csr_trap_sequencer.sv
// Trap / mret sequencer in front of the single-write-port CSR file
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int CAUSE_ECALL   = CAUSE_ECALL_M,
  parameter int CAUSE_ILLEGAL = CAUSE_ILLEGAL_INST
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mem_valid,
  input  logic [31:0]     mem_inst,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            mem_csr_write,
  input  logic            mem_is_mret,
  input  logic [XLEN-1:0] mem_csr_wdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mstatus,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_MEPC    = 3'd1;
  localparam logic [2:0] S_W_MCAUSE  = 3'd2;
  localparam logic [2:0] S_W_MSTATUS = 3'd3;
  localparam logic [2:0] S_RESTORE   = 3'd4;
  localparam logic [2:0] S_REDIRECT  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] ms_trap, ms_mret;
  mem_class_t      cls;
  logic            is_trap;

  csr_trap_decode u_decode (
    .mem_valid_i     (mem_valid),
    .mem_inst_i      (mem_inst),
    .mem_csr_write_i (mem_csr_write),
    .mem_is_mret_i   (mem_is_mret),
    .cls_o           (cls)
  );

  assign is_trap = cls.trap_ecall || cls.trap_unimp;

  // Low PC / mtvec bits are dropped when forming word-aligned addresses
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_q[1:0], csr_mtvec[1:0]};

  // mstatus images for trap entry and mret
  always_comb begin
    ms_trap                       = csr_mstatus;
    ms_trap[MS_MPIE]              = csr_mstatus[MS_MIE];
    ms_trap[MS_MIE]               = 1'b0;
    ms_trap[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
    ms_mret                       = csr_mstatus;
    ms_mret[MS_MIE]               = csr_mstatus[MS_MPIE];
    ms_mret[MS_MPIE]              = 1'b1;
  end

  // State and sequence registers; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state: MEM is only looked at in IDLE, so nothing nests or queues
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (is_trap) begin
          state_d = S_W_MEPC;
          pc_d    = mem_pc;
          cause_d = cls.trap_ecall ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_ILLEGAL);
        end else if (cls.is_mret) begin
          state_d = S_RESTORE;
        end
      end
      S_W_MEPC:   state_d = S_W_MCAUSE;
      S_W_MCAUSE: state_d = S_W_MSTATUS;
      S_W_MSTATUS: begin
        state_d = S_REDIRECT;
        tgt_d   = {csr_mtvec[XLEN-1:2], 2'b00};
      end
      S_RESTORE: begin
        state_d = S_REDIRECT;
        tgt_d   = csr_mepc;
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs and CSR write mux; everything is forced low while reset is held
  always_comb begin
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    busy        = 1'b0;
    if (rstn) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (is_trap || cls.is_mret) begin
            stall = 1'b1;
          end else if (cls.plain_wr) begin
            csr_we    = 1'b1;
            csr_waddr = mem_inst[31:20];
            csr_wdata = mem_csr_wdata;
          end
        end
        S_W_MEPC: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        end
        S_W_MCAUSE: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
        end
        S_W_MSTATUS: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = ms_trap;
        end
        S_RESTORE: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = ms_mret;
        end
        S_REDIRECT: begin
          flush       = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = tgt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Table-driven bench for csr_trap_sequencer plus reset / hold-in-MEM sequences
module tb_csr_trap_sequencer;
  import csr_trap_sequencer_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        csrw;
    logic        mret;
    logic [31:0] wdata;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic        busy;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        clk, rstn;
  logic        mem_valid, mem_csr_write, mem_is_mret;
  logic [31:0] mem_inst, mem_pc, mem_csr_wdata, csr_mtvec, csr_mepc, csr_mstatus;
  logic        csr_we, stall, flush, pc_redirect, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, pc_target;

  int n_checks = 0;
  int n_fail   = 0;
  int n_redir  = 0;
  int n_we     = 0;

  csr_trap_sequencer dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_inst(mem_inst), .mem_pc(mem_pc),
    .mem_csr_write(mem_csr_write), .mem_is_mret(mem_is_mret),
    .mem_csr_wdata(mem_csr_wdata), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(logic v, logic [31:0] inst, logic [31:0] pc, logic cw,
                             logic mr, logic [31:0] wd, logic [31:0] tv,
                             logic [31:0] ep, logic [31:0] ms);
    in_t r;
    r = '{valid:v, inst:inst, pc:pc, csrw:cw, mret:mr, wdata:wd, mtvec:tv, mepc:ep, mstatus:ms};
    return r;
  endfunction

  function automatic out_t mo(logic we, logic [11:0] wa, logic [31:0] wd, logic st,
                              logic fl, logic rd, logic [31:0] tg, logic bz);
    out_t r;
    r = '{we:we, waddr:wa, wdata:wd, stall:st, flush:fl, redir:rd, target:tg, busy:bz};
    return r;
  endfunction

  function automatic vec_t V(string n, in_t i, out_t o);
    vec_t r;
    r.name = n; r.i = i; r.o = o;
    return r;
  endfunction

  task automatic drive(input in_t i);
    mem_valid     = i.valid;
    mem_inst      = i.inst;
    mem_pc        = i.pc;
    mem_csr_write = i.csrw;
    mem_is_mret   = i.mret;
    mem_csr_wdata = i.wdata;
    csr_mtvec     = i.mtvec;
    csr_mepc      = i.mepc;
    csr_mstatus   = i.mstatus;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = mo(csr_we, csr_waddr, csr_wdata, stall, flush, pc_redirect, pc_target, busy);
    n_checks++;
    if (act.redir) n_redir++;
    if (act.we)    n_we++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%0b addr=%h data=%h stall=%0b flush=%0b redir=%0b tgt=%h busy=%0b | want we=%0b addr=%h data=%h stall=%0b flush=%0b redir=%0b tgt=%h busy=%0b",
               name, act.we, act.waddr, act.wdata, act.stall, act.flush, act.redir, act.target, act.busy,
               exp.we, exp.waddr, exp.wdata, exp.stall, exp.flush, exp.redir, exp.target, exp.busy);
    end
  endtask

  // One cycle: drive after the falling edge, sample 1 ns later
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v.i);
    #1;
    check(v.name, v.o);
  endtask

  vec_t tbl[$];
  vec_t seq[$];
  in_t  I_NONE, t1, t2, t3, t3b, t4, t5, t6;
  out_t O_IDLE;

  initial begin
    I_NONE = mi(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    O_IDLE = mo(0, 12'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    t1  = mi(1, INST_ECALL, 32'h100, 0, 0, 32'h0,    32'h204, 32'h0,    32'h8);
    t2  = mi(1, INST_UNIMP, 32'h40,  1, 0, 32'hdead, 32'h207, 32'h0,    32'h88);
    t3  = mi(1, INST_MRET,  32'h0,   0, 1, 32'h0,    32'h0,   32'h104,  32'h1880);
    t3b = mi(1, INST_MRET,  32'h0,   0, 1, 32'h0,    32'h0,   32'h2000, 32'h0);
    t4  = mi(1, 32'h30501073, 32'h500, 1, 0, 32'h300, 32'h0, 32'h0, 32'h0);
    t5  = mi(1, INST_ECALL, 32'h200, 0, 0, 32'h0,    32'h80,  32'h0,    32'h0);
    t6  = mi(1, INST_ECALL, 32'h1fe, 0, 0, 32'h0,    32'h300, 32'h0,    32'h0);

    // ecall: mepc, mcause=11, mstatus 0x8 -> 0x1880, redirect to mtvec at +4
    tbl.push_back(V("t1_detect",   t1, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,   0)));
    tbl.push_back(V("t1_mepc",     t1, mo(1, 12'h341, 32'h100,  1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t1_mcause",   t1, mo(1, 12'h342, 32'd11,   1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t1_mstatus",  t1, mo(1, 12'h300, 32'h1880, 1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t1_redirect", t1, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h204, 1)));
    tbl.push_back(V("t1_idle",     I_NONE, O_IDLE));
    // unimp with csr_write also set: trap wins, mcause=2, mtvec low bits dropped
    tbl.push_back(V("t2_detect",   t2, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,   0)));
    tbl.push_back(V("t2_mepc",     t2, mo(1, 12'h341, 32'h40,   1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t2_mcause",   t2, mo(1, 12'h342, 32'd2,    1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t2_mstatus",  t2, mo(1, 12'h300, 32'h1880, 1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t2_redirect", t2, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h204, 1)));
    tbl.push_back(V("t2_idle",     I_NONE, O_IDLE));
    // mret: mstatus 0x1880 -> 0x1888, redirect to mepc at +2, single-cycle flush
    tbl.push_back(V("t3_detect",   t3, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,   0)));
    tbl.push_back(V("t3_restore",  t3, mo(1, 12'h300, 32'h1888, 1, 0, 0, 32'h0,   1)));
    tbl.push_back(V("t3_redirect", t3, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h104, 1)));
    tbl.push_back(V("t3_idle",     I_NONE, O_IDLE));
    // mret with MPIE=0: MIE stays 0, MPIE set -> 0x80
    tbl.push_back(V("t3b_detect",  t3b, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,    0)));
    tbl.push_back(V("t3b_restore", t3b, mo(1, 12'h300, 32'h80,   1, 0, 0, 32'h0,    1)));
    tbl.push_back(V("t3b_redirect",t3b, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h2000, 1)));
    // csrrw x0, mtvec: same-cycle pass-through write, no stall, no state change
    tbl.push_back(V("t4_plain_wr", t4, mo(1, CSR_MTVEC, 32'h300, 0, 0, 0, 32'h0, 0)));
    tbl.push_back(V("t4_idle",     I_NONE, O_IDLE));
    // Invalid MEM contents are never acted on
    tbl.push_back(V("inv_ecall", mi(0, INST_ECALL, 32'h100, 0, 0, 0, 32'h204, 0, 32'h8), O_IDLE));
    tbl.push_back(V("inv_mret",  mi(0, INST_MRET, 0, 0, 1, 0, 0, 32'h104, 32'h1880), O_IDLE));
    tbl.push_back(V("inv_csrw",  mi(0, 32'h30501073, 0, 1, 0, 32'h300, 0, 0, 0), O_IDLE));

    // Reset state, with a plain CSR write presented at MEM
    rstn = 1'b0;
    drive(t4);
    #3;
    check("reset_outputs", O_IDLE);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[k]) step(tbl[k]);

    // Reset asserted while in W_MCAUSE: outputs drop at once, sequence abandoned
    step(V("t5_detect", t5, mo(0, 12'h0,   32'h0,   1, 0, 0, 32'h0, 0)));
    step(V("t5_mepc",   t5, mo(1, 12'h341, 32'h200, 1, 0, 0, 32'h0, 1)));
    step(V("t5_mcause", t5, mo(1, 12'h342, 32'd11,  1, 0, 0, 32'h0, 1)));
    #1;
    rstn = 1'b0;
    drive(t4);
    #1;
    check("t5_rst_mid", O_IDLE);
    @(posedge clk);
    #1;
    check("t5_rst_held", O_IDLE);
    @(negedge clk);
    drive(I_NONE);
    rstn = 1'b1;
    step(V("t5_post_idle0", I_NONE, O_IDLE));
    step(V("t5_post_idle1", I_NONE, O_IDLE));
    step(V("t5_re_detect",  t5, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,  0)));
    step(V("t5_re_mepc",    t5, mo(1, 12'h341, 32'h200,  1, 0, 0, 32'h0,  1)));
    step(V("t5_re_mcause",  t5, mo(1, 12'h342, 32'd11,   1, 0, 0, 32'h0,  1)));
    step(V("t5_re_mstatus", t5, mo(1, 12'h300, 32'h1800, 1, 0, 0, 32'h0,  1)));
    step(V("t5_re_redir",   t5, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h80, 1)));
    step(V("t5_re_idle",    I_NONE, O_IDLE));

    // ecall held valid in MEM through the whole sequence, then flushed (valid=0)
    n_redir = 0;
    n_we    = 0;
    seq.push_back(V("t6_detect",  t6, mo(0, 12'h0,   32'h0,    1, 0, 0, 32'h0,   0)));
    seq.push_back(V("t6_mepc",    t6, mo(1, 12'h341, 32'h1fc,  1, 0, 0, 32'h0,   1)));
    seq.push_back(V("t6_mcause",  t6, mo(1, 12'h342, 32'd11,   1, 0, 0, 32'h0,   1)));
    seq.push_back(V("t6_mstatus", t6, mo(1, 12'h300, 32'h1800, 1, 0, 0, 32'h0,   1)));
    seq.push_back(V("t6_redir",   t6, mo(0, 12'h0,   32'h0,    0, 1, 1, 32'h300, 1)));
    seq.push_back(V("t6_flushed", mi(0, INST_ECALL, 32'h1fe, 0, 0, 0, 32'h300, 0, 0), O_IDLE));
    seq.push_back(V("t6_idle",    I_NONE, O_IDLE));
    foreach (seq[k]) step(seq[k]);
    n_checks++;
    if (n_redir != 1) begin
      n_fail++;
      $display("FAIL t6_redirect_count: got %0d want 1", n_redir);
    end
    n_checks++;
    if (n_we != 3) begin
      n_fail++;
      $display("FAIL t6_write_count: got %0d want 3", n_we);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
